// File: rtl/imager_pkg.sv
// Shared widths and defaults for the imager subsystem (pixel FIFO and bus side).
package imager_pkg;

    localparam int PIX_W          = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int HOLD_W         = PIX_W * (BYTES_PER_WORD - 1);
    localparam int FIFO_DEPTH     = 256;
    localparam int FIFO_ADDR_W    = 8;

    typedef logic [1:0] byte_idx_t;

    // Drop a pixel into the holding register at byte lane idx (lanes 0..2 only).
    function automatic logic [HOLD_W-1:0] place_pixel(
        input logic [HOLD_W-1:0] hold,
        input logic [PIX_W-1:0]  pix,
        input byte_idx_t         idx
    );
        logic [HOLD_W-1:0] res;
        res = hold;
        case (idx)
            2'd0:    res[7:0]   = pix;
            2'd1:    res[15:8]  = pix;
            2'd2:    res[23:16] = pix;
            default: res        = hold;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The storage array is not reset; only the read register is.
module pixel_fifo_ram
    import imager_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] rd_data_r;

    // Write port: store one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word; holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {WORD_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/pixel_fifo.sv
// Pixel FIFO: packs 8-bit pixel strobes little-endian into 32-bit words,
// buffers them for the bus side and reports flow control and sticky errors.
module pixel_fifo
    import imager_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [PIX_W-1:0]  pixel_data,
    input  logic              frame_end,
    input  logic              flush,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W - 1){1'b0}}, 1'b1};

    byte_idx_t         idx_r;
    logic [HOLD_W-1:0] hold_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              fifo_full_r;
    logic              fifo_empty_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              rd_valid_r;

    byte_idx_t         idx_next_s;
    logic [HOLD_W-1:0] hold_next_s;
    logic [ADDR_W:0]   count_next_s;
    logic              accept_s;
    logic              drop_s;
    logic              pad_drop_s;
    logic              push_s;
    logic [WORD_W-1:0] push_data_s;
    logic              pop_s;
    logic              underrun_s;

    // Packer: accept or drop the strobe, then apply frame-end padding on the result.
    always_comb begin
        accept_s    = write_enable && !fifo_full_r && !flush;
        drop_s      = write_enable && fifo_full_r && !flush;
        pad_drop_s  = 1'b0;
        push_s      = 1'b0;
        push_data_s = {WORD_W{1'b0}};
        idx_next_s  = idx_r;
        hold_next_s = hold_r;

        if (accept_s) begin
            if (idx_r == 2'd3) begin
                push_s      = 1'b1;
                push_data_s = {pixel_data, hold_r};
                idx_next_s  = 2'd0;
                hold_next_s = {HOLD_W{1'b0}};
            end else begin
                idx_next_s  = idx_r + 2'd1;
                hold_next_s = place_pixel(hold_r, pixel_data, idx_r);
            end
        end else begin
            idx_next_s  = idx_r;
            hold_next_s = hold_r;
        end

        // Holding bytes above the index are always zero, so the pad is implicit.
        if (frame_end && !flush && (idx_next_s != 2'd0)) begin
            if (fifo_full_r) begin
                pad_drop_s = 1'b1;
            end else begin
                push_s      = 1'b1;
                push_data_s = {8'h00, hold_next_s};
            end
            idx_next_s  = 2'd0;
            hold_next_s = {HOLD_W{1'b0}};
        end else begin
            pad_drop_s = 1'b0;
        end
    end

    // Pop decision and next word count.
    always_comb begin
        pop_s      = rd_en && !fifo_empty_r && !flush;
        underrun_s = rd_en && fifo_empty_r && !flush;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // State update: flush outranks everything; flags are sticky otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r        <= 2'd0;
            hold_r       <= {HOLD_W{1'b0}};
            wr_ptr_r     <= {ADDR_W{1'b0}};
            rd_ptr_r     <= {ADDR_W{1'b0}};
            count_r      <= {(ADDR_W + 1){1'b0}};
            fifo_full_r  <= 1'b0;
            fifo_empty_r <= 1'b1;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
            rd_valid_r   <= 1'b0;
        end else if (flush) begin
            idx_r        <= 2'd0;
            hold_r       <= {HOLD_W{1'b0}};
            wr_ptr_r     <= {ADDR_W{1'b0}};
            rd_ptr_r     <= {ADDR_W{1'b0}};
            count_r      <= {(ADDR_W + 1){1'b0}};
            fifo_full_r  <= 1'b0;
            fifo_empty_r <= 1'b1;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
            rd_valid_r   <= 1'b0;
        end else begin
            idx_r        <= idx_next_s;
            hold_r       <= hold_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r      <= count_next_s;
            fifo_full_r  <= (count_next_s == FULL_COUNT);
            fifo_empty_r <= (count_next_s == {(ADDR_W + 1){1'b0}});
            overflow_r   <= overflow_r | drop_s | pad_drop_s;
            underflow_r  <= underflow_r | underrun_s;
            rd_valid_r   <= pop_s;
        end
    end

    pixel_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (push_data_s),
        .rd_en   (pop_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data)
    );

    assign rd_valid   = rd_valid_r;
    assign fifo_full  = fifo_full_r;
    assign fifo_empty = fifo_empty_r;
    assign word_count = count_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;

endmodule

// File: tb/tb_pixel_fifo.sv
// Self-checking bench for pixel_fifo against a queue-based reference model.
module tb_pixel_fifo;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              write_enable = 1'b0;
    logic [7:0]        pixel_data = 8'h00;
    logic              frame_end = 1'b0;
    logic              flush = 1'b0;
    logic              rd_en = 1'b0;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   word_count;
    logic              overflow;
    logic              underflow;

    int total_checks = 0;
    int fail_count   = 0;

    // reference model
    logic [31:0] mq[$];
    logic [7:0]  pq[$];
    bit          m_ov = 1'b0;
    bit          m_un = 1'b0;
    logic [31:0] m_data = 32'h0;
    bit          m_valid = 1'b0;

    pixel_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .pixel_data   (pixel_data),
        .frame_end    (frame_end),
        .flush        (flush),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .word_count   (word_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd_data"},    rd_data,             m_data);
        check({tag, ".rd_valid"},   32'(rd_valid),       32'(m_valid));
        check({tag, ".word_count"}, 32'(word_count),     32'(mq.size()));
        check({tag, ".full"},       32'(fifo_full),      32'(mq.size() == DEPTH));
        check({tag, ".empty"},      32'(fifo_empty),     32'(mq.size() == 0));
        check({tag, ".overflow"},   32'(overflow),       32'(m_ov));
        check({tag, ".underflow"},  32'(underflow),      32'(m_un));
    endtask

    function automatic logic [31:0] pack_partial();
        logic [31:0] w = 32'h0;
        for (int i = 0; i < pq.size(); i++) w[8*i +: 8] = pq[i];
        return w;
    endfunction

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
    task automatic step(input string tag, input logic we, input logic [7:0] pix,
                        input logic fe, input logic fl, input logic re);
        bit full_before;
        bit empty_before;
        full_before  = (mq.size() == DEPTH);
        empty_before = (mq.size() == 0);
        write_enable = we; pixel_data = pix; frame_end = fe; flush = fl; rd_en = re;
        @(posedge clk);
        m_valid = 1'b0;
        if (fl) begin
            mq.delete(); pq.delete(); m_ov = 1'b0; m_un = 1'b0;
        end else begin
            if (re && empty_before) m_un = 1'b1;
            if (re && !empty_before) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
            end
            if (we) begin
                if (full_before) m_ov = 1'b1;
                else begin
                    pq.push_back(pix);
                    if (pq.size() == 4) begin
                        mq.push_back(pack_partial());
                        pq.delete();
                    end
                end
            end
            if (fe && pq.size() != 0) begin
                if (full_before) m_ov = 1'b1;
                else mq.push_back(pack_partial());
                pq.delete();
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [7:0] pix);
        step(tag, 1'b1, pix, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string tag);
        step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0; write_enable = 1'b0; frame_end = 1'b0; flush = 1'b0; rd_en = 1'b0;
        #2;
        mq.delete(); pq.delete();
        m_ov = 1'b0; m_un = 1'b0; m_data = 32'h0; m_valid = 1'b0;
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // reset then idle
        repeat (2) @(posedge clk);
        do_reset("reset");
        idle("idle");

        // four bytes -> one word
        wr("pack0", 8'h11); wr("pack1", 8'h22); wr("pack2", 8'h33); wr("pack3", 8'h44);
        check("pack.count_after_4th", 32'(word_count), 32'd1);
        rd("pack.read");
        check("pack.word", rd_data, 32'h44332211);
        idle("pack.idle");
        check("pack.rd_data_holds", rd_data, 32'h44332211);

        // frame_end padding
        wr("pad.a", 8'hAA); wr("pad.b", 8'hBB);
        step("pad.fe", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        wr("pad.c", 8'h01); wr("pad.d", 8'h02);
        step("pad.fe_cc", 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        check("pad.count", 32'(word_count), 32'd2);
        step("pad.fe_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        rd("pad.read1");
        check("pad.word1", rd_data, 32'h0000BBAA);
        rd("pad.read2");
        check("pad.word2", rd_data, 32'h00CC0201);
        // byte that completes a word with frame_end: single push
        wr("pad.e", 8'h05); wr("pad.f", 8'h06); wr("pad.g", 8'h07);
        step("pad.fe_full_word", 1'b1, 8'h08, 1'b1, 1'b0, 1'b0);
        check("pad.one_push", 32'(word_count), 32'd1);
        rd("pad.read3");
        check("pad.word3", rd_data, 32'h08070605);

        // fill to full, then strobe + rd_en together
        for (int i = 0; i < DEPTH * 4; i++) wr("fill", 8'($urandom));
        check("fill.full", 32'(fifo_full), 32'd1);
        step("fill.drop", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        check("fill.overflow", 32'(overflow), 32'd1);
        check("fill.count", 32'(word_count), 32'(DEPTH - 1));

        // drain, then underflow and flush
        for (int i = 0; i < DEPTH - 1; i++) rd("drain");
        step("under.rd", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("under.flag", 32'(underflow), 32'd1);
        check("under.valid", 32'(rd_valid), 32'd0);
        step("flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("flush.flags", {30'd0, overflow, underflow}, 32'd0);

        // mid-frame flush, with a write and read ignored in the same cycle
        for (int i = 0; i < 14; i++) wr("mid.fill", 8'($urandom));
        step("mid.flush", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        wr("mid.n0", 8'hA1); wr("mid.n1", 8'hB2); wr("mid.n2", 8'hC3); wr("mid.n3", 8'hD4);
        check("mid.count", 32'(word_count), 32'd1);
        rd("mid.read");
        check("mid.word", rd_data, 32'hD4C3B2A1);

        // mid-frame reset
        for (int i = 0; i < 14; i++) wr("rst.fill", 8'($urandom));
        do_reset("rst.mid");
        wr("rst.n0", 8'h01); wr("rst.n1", 8'h23); wr("rst.n2", 8'h45); wr("rst.n3", 8'h67);
        check("rst.count", 32'(word_count), 32'd1);
        rd("rst.read");
        check("rst.word", rd_data, 32'h67452301);

        // stream 3*DEPTH words with concurrent random reads and occasional frame ends
        for (int i = 0; i < 3 * DEPTH * 4; i++) begin
            step("stream", 1'b1, 8'($urandom), ($urandom_range(31) == 0) ? 1'b1 : 1'b0,
                 1'b0, ($urandom_range(2) != 0) ? 1'b1 : 1'b0);
        end
        while (mq.size() != 0) rd("stream.drain");
        idle("end");

        $display("%0d/%0d checks passed", total_checks - fail_count, total_checks);
        $finish;
    end

endmodule
